// File: rtl/nr_div_if.sv
// Operand/result handshake bundle for the Newton-Raphson divider.
// master: operand source and result sink; slave: the divider.
interface nr_div_if #(
   parameter int N = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] quo;
   logic [N-1:0] rem;
   logic         dz;
   logic         cerr;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, quo, rem, dz, cerr
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, quo, rem, dz, cerr
   );
endinterface

// File: rtl/nr_div_ctrl.sv
// Newton-Raphson divider controller sharing one external N x N multiplier.
// Reciprocal X is Q2.(N-2); quotient estimate is fixed up by +/-1 steps.
module nr_div_ctrl #(
   parameter int N        = 32,
   parameter int ITER     = 5,
   parameter int CORR_MAX = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   nr_div_if.slave        io,
   output logic [N-1:0]   mul_x,
   output logic [N-1:0]   mul_y,
   input  logic [2*N-1:0] mul_p
);
   localparam int LW = $clog2(N);
   localparam int IW = $clog2(ITER + 1);
   localparam int CW = $clog2(CORR_MAX + 1);
   localparam logic [N-1:0] X3  = {2'b11, {(N-2){1'b0}}};
   localparam logic [N-1:0] TWO = {1'b1, {(N-1){1'b0}}};

   typedef enum logic [2:0] {
      IDLE, NORM, ITA, ITB, QEST, REM, CORR, DONE
   } st_t;

   st_t           st_q, st_d;
   logic [N-1:0]  a_q, b_q, d_q, x_q, t_q, q_q;
   logic [N:0]    r_q;
   logic [LW-1:0] lz_q, lz_c;
   logic [IW-1:0] it_q;
   logic [CW-1:0] cc_q;
   logic          dz_q, cerr_q;
   logic [N-1:0]  d_c, qe_c, qa_c;
   logic [N:0]    bx, rd_c, rr_c, ra_c;
   logic          rr_ok, ra_ok, r_neg, cc_last;
   int            sh;

   // Normalisation, quotient extraction and remainder/correction datapath.
   always_comb begin
      lz_c = '0;
      for (int i = 0; i < N; i++)
         if (b_q[i]) lz_c = LW'(N - 1 - i);
      d_c   = b_q << lz_c;
      sh    = 2 * N - 2 - int'(lz_q);
      qe_c  = N'(mul_p >> sh);
      bx    = {1'b0, b_q};
      rd_c  = {1'b0, a_q} - mul_p[N:0];
      rr_c  = {rd_c[N] | (|mul_p[2*N-1:N+1]), rd_c[N-1:0]};
      rr_ok = !rr_c[N] && (rr_c[N-1:0] < b_q);
      r_neg = r_q[N];
      ra_c  = r_neg ? r_q + bx : r_q - bx;
      qa_c  = r_neg ? q_q - 1'b1 : q_q + 1'b1;
      ra_ok = !ra_c[N] && (ra_c[N-1:0] < b_q);
      cc_last = (cc_q == CW'(CORR_MAX - 1));
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st_q <= IDLE;
      else        st_q <= st_d;
   end

   // Next state and multiplier operand steering.
   always_comb begin
      st_d  = st_q;
      mul_x = '0;
      mul_y = '0;
      unique case (st_q)
         IDLE:
            if (io.in_valid)
               st_d = (io.b == '0) ? DONE : NORM;
         NORM: st_d = ITA;
         ITA: begin
            mul_x = d_q;
            mul_y = x_q;
            st_d  = ITB;
         end
         ITB: begin
            mul_x = x_q;
            mul_y = t_q;
            st_d  = (it_q == IW'(ITER - 1)) ? QEST : ITA;
         end
         QEST: begin
            mul_x = a_q;
            mul_y = x_q;
            st_d  = REM;
         end
         REM: begin
            mul_x = q_q;
            mul_y = b_q;
            st_d  = rr_ok ? DONE : CORR;
         end
         CORR:
            if (ra_ok || cc_last) st_d = DONE;
         DONE:
            if (io.out_ready) st_d = IDLE;
         default: st_d = IDLE;
      endcase
   end

   // Operand capture, reciprocal iteration and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         d_q    <= '0;
         x_q    <= '0;
         t_q    <= '0;
         q_q    <= '0;
         r_q    <= '0;
         lz_q   <= '0;
         it_q   <= '0;
         cc_q   <= '0;
         dz_q   <= 1'b0;
         cerr_q <= 1'b0;
      end else begin
         unique case (st_q)
            IDLE:
               if (io.in_valid) begin
                  a_q    <= io.a;
                  b_q    <= io.b;
                  it_q   <= '0;
                  cc_q   <= '0;
                  dz_q   <= (io.b == '0);
                  cerr_q <= 1'b0;
                  q_q    <= '1;
                  r_q    <= {1'b0, io.a};
               end
            NORM: begin
               lz_q <= lz_c;
               d_q  <= d_c;
               x_q  <= X3 - (d_c >> 1);
            end
            ITA: t_q <= TWO - mul_p[2*N-1:N];
            ITB: begin
               x_q  <= mul_p[2*N-3:N-2];
               it_q <= it_q + 1'b1;
            end
            QEST: q_q <= qe_c;
            REM:  r_q <= rr_c;
            CORR: begin
               q_q  <= qa_c;
               r_q  <= ra_c;
               cc_q <= cc_q + 1'b1;
               if (!ra_ok && cc_last) cerr_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign io.in_ready  = (st_q == IDLE);
   assign io.out_valid = (st_q == DONE);
   assign io.quo       = q_q;
   assign io.rem       = r_q[N-1:0];
   assign io.dz        = dz_q;
   assign io.cerr      = cerr_q;

   // A correction step must never wrap the quotient past all-ones.
   q_ovf_a: assert property (@(posedge clk) disable iff (!rst_n)
      !(st_q == CORR && !r_q[N] && q_q == '1));

endmodule
